hsi_frame_assembler: RTL and testbench

Consumes the 32-bit word stream produced by the HSI tokenizer (one `token_valid` pulse per received word) and assembles it into gyro frames. Each frame is a sync header, `N_PAYLOAD` data words and an XOR checksum word. A frame that passes its checks is committed to a holding register that the AXI register side reads. Sync, checksum, sequence, timeout and overrun errors are counted in saturating counters exposed to software.

---
 rtl/hsi_frame_assembler.sv | 203 ++++++++++++++++++++
 tb/tb_hsi_frame_assembler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hsi_frame_assembler.sv
// Assembles HSI tokenizer words into sync/payload/checksum gyro frames and
// commits checked frames to a holding register with saturating error counters.
module hsi_frame_assembler #(
  parameter logic [7:0] SYNC      = 8'hA5,
  parameter int         N_PAYLOAD = 3,
  parameter int         TIMEOUT   = 1024
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   clear_counters,
  input  logic [31:0]            token_data,
  input  logic                   token_valid,
  input  logic                   frame_ack,
  output logic                   frame_valid,
  output logic                   frame_pulse,
  output logic [31:0]            header_out,
  output logic [32*N_PAYLOAD-1:0] payload_out,
  output logic [15:0]            sync_err_cnt,
  output logic [15:0]            crc_err_cnt,
  output logic [15:0]            seq_err_cnt,
  output logic [15:0]            timeout_err_cnt,
  output logic [15:0]            overrun_cnt
);

  localparam int IDX_W  = (N_PAYLOAD > 1) ? $clog2(N_PAYLOAD) : 1;
  localparam int IDLE_W = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_PAYLOAD - 1);
  localparam logic [IDLE_W-1:0] LAST_IDLE = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t                   state_r, state_s;
  logic [31:0]              acc_r;
  logic [31:0]              hdr_r;
  logic [32*N_PAYLOAD-1:0]  slots_r;
  logic [IDX_W-1:0]         idx_r;
  logic [IDLE_W-1:0]        idle_r;
  logic                     commit_r;
  logic [7:0]               last_seq_r;
  logic                     seq_valid_r;

  logic sync_bad_s, crc_bad_s, commit_s, timeout_s, hdr_load_s, pay_load_s;
  logic seq_gap_s, overrun_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    if (cnt == 16'hFFFF) begin
      return cnt;
    end else begin
      return cnt + 16'd1;
    end
  endfunction

  // Next-state decode and per-token event flags.
  always_comb begin
    state_s    = state_r;
    sync_bad_s = 1'b0;
    crc_bad_s  = 1'b0;
    commit_s   = 1'b0;
    timeout_s  = 1'b0;
    hdr_load_s = 1'b0;
    pay_load_s = 1'b0;
    if (!enable) begin
      state_s = HUNT;
    end else begin
      case (state_r)
        HUNT: begin
          if (token_valid && (token_data[31:24] == SYNC)) begin
            hdr_load_s = 1'b1;
            state_s    = PAYLOAD;
          end else if (token_valid) begin
            sync_bad_s = 1'b1;
          end else begin
            state_s = HUNT;
          end
        end
        PAYLOAD: begin
          if (token_valid) begin
            pay_load_s = 1'b1;
            state_s    = (idx_r == LAST_IDX) ? CHECK : PAYLOAD;
          end else if (idle_r == LAST_IDLE) begin
            timeout_s = 1'b1;
            state_s   = HUNT;
          end else begin
            state_s = PAYLOAD;
          end
        end
        CHECK: begin
          if (token_valid) begin
            commit_s  = (token_data == acc_r);
            crc_bad_s = (token_data != acc_r);
            state_s   = HUNT;
          end else if (idle_r == LAST_IDLE) begin
            timeout_s = 1'b1;
            state_s   = HUNT;
          end else begin
            state_s = CHECK;
          end
        end
        default: begin
          state_s = HUNT;
        end
      endcase
    end
  end

  // Commit-stage side effects, evaluated on the cycle after the checksum token.
  always_comb begin
    seq_gap_s = commit_r && seq_valid_r && (hdr_r[23:16] != (last_seq_r + 8'd1));
    overrun_s = commit_r && frame_valid && !frame_ack;
  end

  // Frame-building datapath: state, header/payload capture, checksum and idle count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= HUNT;
      acc_r   <= 32'd0;
      hdr_r   <= 32'd0;
      slots_r <= '0;
      idx_r   <= '0;
      idle_r  <= '0;
    end else begin
      state_r <= state_s;
      if (hdr_load_s) begin
        hdr_r <= token_data;
        acc_r <= token_data;
        idx_r <= '0;
      end else if (pay_load_s) begin
        for (int i = 0; i < N_PAYLOAD; i++) begin
          if (idx_r == IDX_W'(i)) begin
            slots_r[32*i +: 32] <= token_data;
          end
        end
        acc_r <= acc_r ^ token_data;
        if (idx_r != LAST_IDX) begin
          idx_r <= idx_r + IDX_W'(1);
        end
      end
      // Idle cycles only matter while a frame is partially assembled.
      if (!enable || (state_r == HUNT) || token_valid || timeout_s) begin
        idle_r <= '0;
      end else begin
        idle_r <= idle_r + IDLE_W'(1);
      end
    end
  end

  // Holding register, commit strobe and sequence reference.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      commit_r    <= 1'b0;
      frame_pulse <= 1'b0;
      frame_valid <= 1'b0;
      header_out  <= 32'd0;
      payload_out <= '0;
      last_seq_r  <= 8'd0;
      seq_valid_r <= 1'b0;
    end else begin
      commit_r    <= commit_s;
      frame_pulse <= commit_r;
      if (commit_r) begin
        frame_valid <= 1'b1;
        header_out  <= hdr_r;
        payload_out <= slots_r;
        last_seq_r  <= hdr_r[23:16];
        seq_valid_r <= 1'b1;
      end else if (frame_ack) begin
        frame_valid <= 1'b0;
      end
      if (!enable) begin
        seq_valid_r <= 1'b0;
      end
    end
  end

  // Saturating error counters; a clear wins over a same-cycle increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_err_cnt    <= 16'd0;
      crc_err_cnt     <= 16'd0;
      seq_err_cnt     <= 16'd0;
      timeout_err_cnt <= 16'd0;
      overrun_cnt     <= 16'd0;
    end else if (clear_counters) begin
      sync_err_cnt    <= 16'd0;
      crc_err_cnt     <= 16'd0;
      seq_err_cnt     <= 16'd0;
      timeout_err_cnt <= 16'd0;
      overrun_cnt     <= 16'd0;
    end else begin
      if (sync_bad_s) sync_err_cnt    <= sat_inc(sync_err_cnt);
      if (crc_bad_s)  crc_err_cnt     <= sat_inc(crc_err_cnt);
      if (seq_gap_s)  seq_err_cnt     <= sat_inc(seq_err_cnt);
      if (timeout_s)  timeout_err_cnt <= sat_inc(timeout_err_cnt);
      if (overrun_s)  overrun_cnt     <= sat_inc(overrun_cnt);
    end
  end

endmodule

// File: tb/tb_hsi_frame_assembler.sv
// Randomized and directed bench for hsi_frame_assembler against a frame-level
// queue model of the assembler rules.
module tb_hsi_frame_assembler;
  localparam logic [7:0] SYNC      = 8'hA5;
  localparam int         N_PAYLOAD = 3;
  localparam int         TIMEOUT   = 16;

  logic                    clock = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    enable = 1'b0;
  logic                    clear_counters = 1'b0;
  logic [31:0]             token_data = 32'd0;
  logic                    token_valid = 1'b0;
  logic                    frame_ack = 1'b0;
  logic                    frame_valid, frame_pulse;
  logic [31:0]             header_out;
  logic [32*N_PAYLOAD-1:0] payload_out;
  logic [15:0]             sync_err_cnt, crc_err_cnt, seq_err_cnt, timeout_err_cnt, overrun_cnt;

  hsi_frame_assembler #(.SYNC(SYNC), .N_PAYLOAD(N_PAYLOAD), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .clear_counters(clear_counters),
    .token_data(token_data), .token_valid(token_valid), .frame_ack(frame_ack),
    .frame_valid(frame_valid), .frame_pulse(frame_pulse), .header_out(header_out),
    .payload_out(payload_out), .sync_err_cnt(sync_err_cnt), .crc_err_cnt(crc_err_cnt),
    .seq_err_cnt(seq_err_cnt), .timeout_err_cnt(timeout_err_cnt), .overrun_cnt(overrun_cnt)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  logic [31:0]             m_frame[$];
  int                      m_idle, m_sync, m_crc, m_seq, m_tmo, m_ovr, m_last_seq;
  bit                      m_seqv, m_valid, m_pulse, m_pend;
  logic [31:0]             m_hdr, m_pend_hdr;
  logic [32*N_PAYLOAD-1:0] m_pay, m_pend_pay;
  logic [31:0]             fw[N_PAYLOAD+2];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int c);
    return (c >= 65535) ? 65535 : c + 1;
  endfunction

  task automatic m_reset();
    m_frame.delete();
    m_idle = 0; m_sync = 0; m_crc = 0; m_seq = 0; m_tmo = 0; m_ovr = 0; m_last_seq = 0;
    m_seqv = 0; m_valid = 0; m_pulse = 0; m_pend = 0;
    m_hdr = '0; m_pay = '0; m_pend_hdr = '0; m_pend_pay = '0;
  endtask

  // One clock edge of the model, using the inputs presented in this cycle.
  task automatic m_cycle(input bit tv, input logic [31:0] w);
    logic [31:0] x;
    m_pulse = 1'b0;
    if (m_pend) begin
      if (m_valid && !frame_ack) m_ovr = sat(m_ovr);
      if (m_seqv && (int'(m_pend_hdr[23:16]) != (m_last_seq + 1) % 256)) m_seq = sat(m_seq);
      m_last_seq = int'(m_pend_hdr[23:16]);
      m_seqv = 1; m_hdr = m_pend_hdr; m_pay = m_pend_pay; m_valid = 1; m_pulse = 1; m_pend = 0;
    end else if (frame_ack) begin
      m_valid = 0;
    end
    if (!enable) begin
      m_frame.delete(); m_idle = 0; m_seqv = 0;
    end else if (tv) begin
      m_idle = 0;
      if (m_frame.size() == 0) begin
        if (w[31:24] == SYNC) m_frame.push_back(w);
        else m_sync = sat(m_sync);
      end else if (m_frame.size() < N_PAYLOAD + 1) begin
        m_frame.push_back(w);
      end else begin
        x = 32'd0;
        foreach (m_frame[i]) x = x ^ m_frame[i];
        if (x == w) begin
          m_pend = 1; m_pend_hdr = m_frame[0];
          for (int i = 0; i < N_PAYLOAD; i++) m_pend_pay[32*i +: 32] = m_frame[i+1];
        end else begin
          m_crc = sat(m_crc);
        end
        m_frame.delete();
      end
    end else if (m_frame.size() != 0) begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        m_tmo = sat(m_tmo); m_frame.delete(); m_idle = 0;
      end
    end
    if (clear_counters) begin
      m_sync = 0; m_crc = 0; m_seq = 0; m_tmo = 0; m_ovr = 0;
    end
  endtask

  task automatic drive_tok(input logic [31:0] w);
    token_valid = 1'b1; token_data = w;
    m_cycle(1'b1, w);
    @(negedge clock);
    token_valid = 1'b0;
  endtask

  task automatic drive_idle(input int n);
    token_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      m_cycle(1'b0, 32'd0);
      @(negedge clock);
    end
  endtask

  task automatic do_ack();
    frame_ack = 1'b1; drive_idle(1); frame_ack = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".valid"}, frame_valid, m_valid);
    check_eq({tag, ".pulse"}, frame_pulse, m_pulse);
    check_eq({tag, ".header"}, header_out, m_hdr);
    check_eq({tag, ".payload"}, payload_out, m_pay);
    check_eq({tag, ".sync_cnt"}, sync_err_cnt, m_sync);
    check_eq({tag, ".crc_cnt"}, crc_err_cnt, m_crc);
    check_eq({tag, ".seq_cnt"}, seq_err_cnt, m_seq);
    check_eq({tag, ".tmo_cnt"}, timeout_err_cnt, m_tmo);
    check_eq({tag, ".ovr_cnt"}, overrun_cnt, m_ovr);
  endtask

  task automatic build_fw(input logic [7:0] seq, input logic [15:0] flags, input bit random_pay);
    fw[0] = {SYNC, seq, flags};
    for (int i = 1; i <= N_PAYLOAD; i++) fw[i] = random_pay ? $urandom : 32'(11 * (1 << (i - 1))) + 32'(i * 0);
    fw[N_PAYLOAD+1] = 32'd0;
    for (int i = 0; i <= N_PAYLOAD; i++) fw[N_PAYLOAD+1] = fw[N_PAYLOAD+1] ^ fw[i];
  endtask

  task automatic send_fw(input int maxgap, input int long_at);
    for (int i = 0; i < N_PAYLOAD + 2; i++) begin
      drive_tok(fw[i]);
      if (i < N_PAYLOAD + 1) begin
        if (i == long_at) drive_idle(TIMEOUT + 1);
        else drive_idle(int'($urandom_range(maxgap, 0)));
      end
    end
  endtask

  initial begin
    m_reset();
    #2;
    check_all("reset");
    @(negedge clock);
    reset_n = 1'b1; enable = 1'b1;
    drive_idle(2);

    // Good frame: payload words 0x11, 0x22, 0x44
    fw[0] = 32'hA5010000; fw[1] = 32'h11; fw[2] = 32'h22; fw[3] = 32'h44; fw[4] = 32'hA5010077;
    send_fw(0, -1);
    drive_idle(1);
    check_eq("t1.pulse", frame_pulse, 1'b1);
    check_eq("t1.header", header_out, 32'hA5010000);
    check_eq("t1.payload", payload_out, 96'h00000044_00000022_00000011);
    check_all("t1");
    drive_idle(1);
    check_all("t1b");

    // Bad checksum, then a good frame
    do_ack();
    fw[0] = 32'hA5020000; fw[4] = 32'hA5020076;
    send_fw(0, -1); drive_idle(2);
    check_eq("t2.crc", crc_err_cnt, 16'd1);
    check_all("t2");
    fw[4] = 32'hA5020077;
    send_fw(1, -1); drive_idle(2);
    check_all("t2b");

    // Sync hunt
    do_ack();
    drive_tok(32'h12345678); drive_tok(32'h00000000);
    build_fw(8'h03, 16'h0000, 1'b0); send_fw(0, -1); drive_idle(2);
    check_eq("t3.sync", sync_err_cnt, 16'd2);
    check_all("t3");

    // Sequence gap with overrun, ack, then ack coinciding with commit
    do_ack();
    build_fw(8'h04, 16'h1234, 1'b1); send_fw(0, -1); drive_idle(2);
    build_fw(8'h06, 16'h0000, 1'b1); send_fw(0, -1); drive_idle(2);
    check_eq("t4.header", header_out, 32'hA5060000);
    check_eq("t4.seq", seq_err_cnt, 16'd1);
    check_eq("t4.ovr", overrun_cnt, 16'd1);
    check_all("t4");
    do_ack();
    check_eq("t4.ack", frame_valid, 1'b0);
    build_fw(8'h07, 16'h0000, 1'b1); send_fw(0, -1); drive_idle(2);
    build_fw(8'h08, 16'h0000, 1'b1); send_fw(0, -1);
    frame_ack = 1'b1; drive_idle(1); frame_ack = 1'b0;
    check_eq("t4.ack_commit", frame_valid, 1'b1);
    check_eq("t4.ovr_hold", overrun_cnt, 16'd1);
    check_all("t4b");

    // Timeout: 15 idle cycles tolerated, the 16th aborts
    drive_tok({SYNC, 8'h09, 16'h0}); drive_tok(32'h55);
    drive_idle(TIMEOUT - 1);
    check_eq("t5.pre", timeout_err_cnt, 16'd0);
    drive_idle(1);
    check_eq("t5.tmo", timeout_err_cnt, 16'd1);
    check_all("t5");
    build_fw(8'h09, 16'h0000, 1'b1); send_fw(0, -1); drive_idle(2);
    check_all("t5b");

    // Disable mid-frame: partial discarded, outputs held, reference invalidated
    drive_tok({SYNC, 8'h0A, 16'h0}); drive_tok(32'h66);
    enable = 1'b0;
    drive_tok(32'h77); drive_tok(32'h12345678); drive_idle(2);
    enable = 1'b1;
    check_all("t6.dis");
    build_fw(8'h40, 16'h0000, 1'b1); send_fw(0, -1); drive_idle(2);
    check_all("t6.reen");

    // Clear in the same cycle as an increment
    clear_counters = 1'b1; drive_tok(32'h0BAD0BAD); clear_counters = 1'b0;
    drive_idle(1);
    check_all("t6.clr");

    // Saturation of the sync counter
    for (int i = 0; i < 65535; i++) drive_tok(32'h00C0FFEE);
    drive_idle(1);
    check_eq("t6.sat", sync_err_cnt, 16'hFFFF);
    drive_tok(32'h00C0FFEE); drive_idle(1);
    check_eq("t6.sat2", sync_err_cnt, 16'hFFFF);
    check_all("t6.sat3");

    // Reset mid-frame
    drive_tok({SYNC, 8'h50, 16'h0}); drive_tok(32'h99);
    reset_n = 1'b0; m_reset();
    #1;
    check_eq("t6.rst_valid", frame_valid, 1'b0);
    check_eq("t6.rst_sync", sync_err_cnt, 16'd0);
    check_all("t6.rst");
    @(negedge clock);
    reset_n = 1'b1;
    build_fw(8'h77, 16'h0000, 1'b1); send_fw(0, -1); drive_idle(2);
    check_all("t6.post");

    // Randomized frames with junk, gaps, corruption, timeouts and acks
    for (int it = 0; it < 300; it++) begin
      logic [7:0] s;
      s = ($urandom_range(9, 0) < 7) ? 8'(m_last_seq + 1) : 8'($urandom);
      if ($urandom_range(9, 0) == 0) drive_tok($urandom);
      build_fw(s, 16'($urandom), 1'b1);
      if ($urandom_range(6, 0) == 0) fw[N_PAYLOAD+1][$urandom_range(31, 0)] ^= 1'b1;
      send_fw(2, ($urandom_range(19, 0) == 0) ? int'($urandom_range(N_PAYLOAD, 0)) : -1);
      drive_idle(1);
      check_eq("rnd.pulse", frame_pulse, m_pulse);
      drive_idle(1);
      check_all("rnd");
      if ($urandom_range(1, 0) == 1) do_ack();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
